// File: rtl/tester_pkg.sv
// Shared types and pattern-word field layout for the pattern replay checker.
// Word layout, MSB first: {stim[IN_W], exp[OUT_W], mask[OUT_W]}.
package tester_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD    = 3'd2,
        S_WAIT    = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam int unsigned MASK_LSB = 0;

    function automatic int unsigned word_w(input int unsigned in_w, input int unsigned out_w);
        return in_w + 2 * out_w;
    endfunction

    function automatic int unsigned exp_lsb(input int unsigned out_w);
        return out_w;
    endfunction

    function automatic int unsigned stim_lsb(input int unsigned out_w);
        return 2 * out_w;
    endfunction

endpackage

// File: rtl/pattern_replay_checker.sv
// Replays stored stimulus/expect/mask vectors into a DUT and reports masked
// compare results: pass, mismatch count and first failing index.
module pattern_replay_checker
    import tester_pkg::*;
#(
    parameter int unsigned IN_W   = 2,
    parameter int unsigned OUT_W  = 1,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ADDR_W:0]               num_pat,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [IN_W+2*OUT_W-1:0]       mem_rdata,
    output logic [IN_W-1:0]               dut_in,
    input  logic [OUT_W-1:0]              dut_out,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [ADDR_W:0]               fail_count,
    output logic                          first_fail_vld,
    output logic [ADDR_W-1:0]             first_fail_idx
);

    localparam int unsigned WORD_W = word_w(IN_W, OUT_W);
    localparam int unsigned EXP_L  = exp_lsb(OUT_W);
    localparam int unsigned STIM_L = stim_lsb(OUT_W);
    localparam int unsigned CNT_W  = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(2 ** ADDR_W);

    state_t                 state;
    logic [ADDR_W-1:0]      idx;
    logic [ADDR_W:0]        num_lat;
    logic [OUT_W-1:0]       exp_q;
    logic [OUT_W-1:0]       mask_q;
    logic [CNT_W-1:0]       cnt;

    logic [OUT_W-1:0]       diff_c;
    logic                   mismatch_c;
    logic [ADDR_W:0]        fail_next_c;
    logic                   last_c;

    // Masked compare; any unmasked X/Z makes the reduction non-0 and counts as a mismatch.
    always_comb begin
        diff_c      = (dut_out ^ exp_q) & mask_q;
        mismatch_c  = ((|diff_c) !== 1'b0);
        fail_next_c = fail_count + (ADDR_W + 1)'(mismatch_c);
        last_c      = ({1'b0, idx} == (num_lat - (ADDR_W + 1)'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            num_lat        <= '0;
            exp_q          <= '0;
            mask_q         <= '0;
            cnt            <= '0;
            mem_rd_en      <= 1'b0;
            mem_addr       <= '0;
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_lat        <= (num_pat > DEPTH_V) ? DEPTH_V : num_pat;
                        idx            <= '0;
                        fail_count     <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                        if (num_pat == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state     <= S_FETCH;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                        end
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    dut_in <= mem_rdata[STIM_L +: IN_W];
                    exp_q  <= mem_rdata[EXP_L +: OUT_W];
                    mask_q <= mem_rdata[MASK_LSB +: OUT_W];
                    cnt    <= CNT_W'(SETTLE);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_COMPARE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_COMPARE: begin
                    fail_count <= fail_next_c;
                    if (mismatch_c && !first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= idx;
                    end
                    if (last_c) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (fail_next_c == '0);
                    end else begin
                        idx       <= idx + ADDR_W'(1);
                        mem_addr  <= idx + ADDR_W'(1);
                        mem_rd_en <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_w;
    assign unused_w = ^WORD_W;

endmodule
